// File: rtl/key_pkg.sv
// Shared constants for the keyboard scheduler: set-2 scancodes, key indices,
// direction codes and the update-path FSM encoding.
// Pure declarations; no timing or flow control of its own.
package key_pkg;

  localparam int NUM_KEYS = 10;

  // Set-2 make codes for the game keys
  localparam logic [7:0] SC_W     = 8'h1D,
                         SC_A     = 8'h1C,
                         SC_S     = 8'h1B,
                         SC_D     = 8'h23,
                         SC_I     = 8'h43,
                         SC_J     = 8'h3B,
                         SC_K     = 8'h42,
                         SC_L     = 8'h4B,
                         SC_SPACE = 8'h29,
                         SC_ESC   = 8'h76,
                         SC_BREAK = 8'hF0;

  // Bit positions in the held/press bitmaps
  localparam int KEY_W     = 0,
                 KEY_A     = 1,
                 KEY_S     = 2,
                 KEY_D     = 3,
                 KEY_I     = 4,
                 KEY_J     = 5,
                 KEY_K     = 6,
                 KEY_L     = 7,
                 KEY_SPACE = 8,
                 KEY_ESC   = 9;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  // Scancode to one-hot key hit; anything outside the table (including F0) is all-zero
  function automatic logic [NUM_KEYS-1:0] key_lookup(input logic [7:0] sc);
    logic [NUM_KEYS-1:0] hit;
    hit            = '0;
    hit[KEY_W]     = (sc == SC_W);
    hit[KEY_A]     = (sc == SC_A);
    hit[KEY_S]     = (sc == SC_S);
    hit[KEY_D]     = (sc == SC_D);
    hit[KEY_I]     = (sc == SC_I);
    hit[KEY_J]     = (sc == SC_J);
    hit[KEY_K]     = (sc == SC_K);
    hit[KEY_L]     = (sc == SC_L);
    hit[KEY_SPACE] = (sc == SC_SPACE);
    hit[KEY_ESC]   = (sc == SC_ESC);
    return hit;
  endfunction

  // Lowest set bit wins (up > left > down > right); empty vector gives DIR_NONE
  function automatic dir_t dir_pick(input logic [3:0] v);
    dir_t d;
    d = DIR_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) d = dir_t'(i + 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/key_dir_arbiter.sv
// Per-player direction arbiter: last-pressed key wins, fallback by priority on release.
// Latency: dir registers the held/press vectors presented in the same cycle (one edge).
// No backpressure: held/press are sampled every cycle, press is a one-cycle strobe.
module key_dir_arbiter
  import key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] held,
  input  logic [3:0] press,
  output dir_t       dir
);

  logic cur_held;
  dir_t dir_nxt;

  // Next direction: a fresh press takes over, losing the current key falls back by priority
  always_comb begin
    cur_held = 1'b0;
    case (dir)
      DIR_UP:    cur_held = held[0];
      DIR_LEFT:  cur_held = held[1];
      DIR_DOWN:  cur_held = held[2];
      DIR_RIGHT: cur_held = held[3];
      default:   cur_held = 1'b0;
    endcase
    dir_nxt = dir;
    if (press != 4'b0000) begin
      dir_nxt = dir_pick(press);
    end else if (dir != DIR_NONE && !cur_held) begin
      dir_nxt = dir_pick(held);
    end
  end

  // Direction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= DIR_NONE;
    else     dir <= dir_nxt;
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Keycode stream to held-key bitmap, press pulses, per-player direction and game reset.
// Latency: keycode change latched at edge N, outputs update at edge N+2; events >= 3 cycles apart.
// No backpressure: keycode changes during LOOKUP/APPLY are dropped, only the latest value is seen.
// Optional: define KEY_RESET_HOLD_EN to require Space held RESET_HOLD_CYCLES before game_reset.
module key_event_scheduler
  import key_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 65_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         keycode,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [2:0]          p1_dir,
  output logic [2:0]          p2_dir,
  output logic                game_reset
);

  state_t              state;
  logic [15:0]         kc_q;
  logic [NUM_KEYS-1:0] hit_q;
  logic                brk_q;
  logic [NUM_KEYS-1:0] held_nxt;
  logic [NUM_KEYS-1:0] press_nxt;
  dir_t                p1_dir_e;
  dir_t                p2_dir_e;

  // Held/press values that APPLY commits; outside APPLY they hold state and press is idle
  always_comb begin
    held_nxt  = key_held;
    press_nxt = '0;
    if (state == ST_APPLY) begin
      if (brk_q) begin
        held_nxt = key_held & ~hit_q;
      end else begin
        held_nxt  = key_held | hit_q;
        press_nxt = hit_q & ~key_held;
      end
    end
  end

  // Update-path FSM with registered held/press outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      kc_q      <= 16'h0000;
      hit_q     <= '0;
      brk_q     <= 1'b0;
      key_held  <= '0;
      key_press <= '0;
    end else begin
      key_held  <= held_nxt;
      key_press <= press_nxt;
      case (state)
        ST_IDLE: begin
          if (keycode != kc_q) begin
            kc_q  <= keycode;
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_q <= key_lookup(kc_q[7:0]);
          brk_q <= (kc_q[15:8] == SC_BREAK);
          state <= ST_APPLY;
        end
        ST_APPLY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Arbiters see the same next-state vectors as key_held so dir moves on the APPLY edge
  key_dir_arbiter u_p1_arb (
    .clk   (clk),
    .rst   (rst),
    .held  (held_nxt[KEY_D:KEY_W]),
    .press (press_nxt[KEY_D:KEY_W]),
    .dir   (p1_dir_e)
  );

  key_dir_arbiter u_p2_arb (
    .clk   (clk),
    .rst   (rst),
    .held  (held_nxt[KEY_L:KEY_I]),
    .press (press_nxt[KEY_L:KEY_I]),
    .dir   (p2_dir_e)
  );

  assign p1_dir = p1_dir_e;
  assign p2_dir = p2_dir_e;

`ifdef KEY_RESET_HOLD_EN
  localparam int unsigned        HOLD_W    = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Saturating hold counter; release in APPLY clears it together with game_reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      game_reset <= 1'b0;
    end else if (state == ST_APPLY && !held_nxt[KEY_SPACE]) begin
      hold_cnt   <= '0;
      game_reset <= 1'b0;
    end else if (key_held[KEY_SPACE]) begin
      if (hold_cnt != HOLD_MAX)  hold_cnt   <= hold_cnt + 1'b1;
      if (hold_cnt == HOLD_LAST) game_reset <= 1'b1;
    end
  end
`else
  assign game_reset = key_held[KEY_SPACE];

  // The hold length only matters when the hold counter is built in
  if (RESET_HOLD_CYCLES == 0) begin : g_hold_len_unused
  end
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Randomized self-checking bench for key_event_scheduler against an event-level model.
// Model: each accepted keycode becomes visible two edges after it is latched; next accept 3 edges on.
// Keycodes are driven after the falling edge and outputs are sampled on the falling edge.
module tb_key_event_scheduler;

  localparam int unsigned HOLD = 20;

  logic        clk;
  logic        rst;
  logic [15:0] keycode;
  logic [9:0]  key_held;
  logic [9:0]  key_press;
  logic [2:0]  p1_dir;
  logic [2:0]  p2_dir;
  logic        game_reset;

  key_event_scheduler #(.RESET_HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .keycode    (keycode),
    .key_held   (key_held),
    .key_press  (key_press),
    .p1_dir     (p1_dir),
    .p2_dir     (p2_dir),
    .game_reset (game_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Scancodes in key-index order
  logic [7:0] sc_tab [10];

  // Expected (visible) state and the pending event waiting to become visible
  logic [9:0]  e_held, e_press, p_held, p_press;
  logic [2:0]  e_p1, e_p2, p_p1, p_p2;
  logic        e_gr;
  logic [15:0] m_last;
  bit          pend_vld;
  int          pend_at, ready, cyc, hold_edge;
  logic [7:0]  prev_b;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_held = '0; e_press = '0; e_p1 = '0; e_p2 = '0; e_gr = 1'b0;
    pend_vld = 0; m_last = 16'h0000; ready = 0; hold_edge = 0;
  endtask

  // Work out the effect of one keycode from the currently visible state
  task automatic model_decode(input logic [15:0] kc);
    int idx, base, pd;
    bit brk;
    idx = -1;
    for (int i = 0; i < 10; i++) if (sc_tab[i] == kc[7:0]) idx = i;
    p_held = e_held; p_press = '0; p_p1 = e_p1; p_p2 = e_p2;
    if (idx < 0) return;
    brk = (kc[15:8] == 8'hF0);
    if (brk) p_held[idx] = 1'b0;
    else begin
      if (!e_held[idx]) p_press[idx] = 1'b1;
      p_held[idx] = 1'b1;
    end
    if (idx < 8) begin
      base = (idx / 4) * 4;
      pd   = (idx < 4) ? int'(p_p1) : int'(p_p2);
      if (p_press[idx]) pd = idx - base + 1;
      else if (brk && pd == idx - base + 1) begin
        pd = 0;
        for (int k = 3; k >= 0; k--) if (p_held[base + k]) pd = k + 1;
      end
      if (idx < 4) p_p1 = 3'(pd);
      else         p_p2 = 3'(pd);
    end
  endtask

  // Advance the model by one rising edge
  task automatic model_edge();
    cyc++;
    e_press = '0;
    if (pend_vld && cyc == pend_at) begin
      if (!e_held[8] && p_held[8]) hold_edge = cyc;
      e_held = p_held; e_press = p_press; e_p1 = p_p1; e_p2 = p_p2;
      pend_vld = 0;
    end
    if (!pend_vld && cyc >= ready && keycode != m_last) begin
      m_last = keycode;
      model_decode(keycode);
      pend_vld = 1;
      pend_at  = cyc + 2;
      ready    = cyc + 3;
    end
`ifdef KEY_RESET_HOLD_EN
    e_gr = e_held[8] && (cyc - hold_edge >= int'(HOLD));
`else
    e_gr = e_held[8];
`endif
  endtask

  task automatic check_all();
    check_val("held",  16'(key_held),   16'(e_held));
    check_val("press", 16'(key_press),  16'(e_press));
    check_val("p1dir", 16'(p1_dir),     16'(e_p1));
    check_val("p2dir", 16'(p2_dir),     16'(e_p2));
    check_val("greset", 16'(game_reset), 16'(e_gr));
  endtask

  // Drive kc for n cycles, checking every cycle
  task automatic hold(input logic [15:0] kc, input int n);
    for (int i = 0; i < n; i++) begin
      keycode = kc;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [15:0] kc;
    kc = {prev_b, b};
    prev_b = b;
    hold(kc, int'($urandom_range(1, 6)));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_held"},  16'(key_held),  16'h0);
    check_val({tag, "_press"}, 16'(key_press), 16'h0);
    check_val({tag, "_p1"},    16'(p1_dir),    16'h0);
    check_val({tag, "_p2"},    16'(p2_dir),    16'h0);
    check_val({tag, "_gr"},    16'(game_reset), 16'h0);
  endtask

  initial begin
    int pulses;
    int r, k;
    sc_tab = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h29, 8'h76};
    cyc = 0;
    prev_b = 8'h00;
    model_reset();
    rst = 1'b1;
    keycode = 16'h0000;
    #1;
    check_zero("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // W make: visible two edges after the latch edge
    hold(16'h001D, 3);
    check_val("w_held", 16'(key_held), 16'h0001);
    check_val("w_press", 16'(key_press), 16'h0001);
    check_val("w_dir", 16'(p1_dir), 16'd1);
    hold(16'h001D, 1);
    check_val("w_press_end", 16'(key_press), 16'h0000);

    // W break
    hold(16'h1DF0, 3);
    hold(16'hF01D, 3);
    check_val("wbrk_held", 16'(key_held), 16'h0000);
    check_val("wbrk_dir", 16'(p1_dir), 16'd0);

    // Long steady make gives one pulse only
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      hold(16'h001D, 1);
      if (key_press[0]) pulses++;
    end
    check_val("one_pulse", 16'(pulses), 16'd1);

    // Last pressed wins, then priority fallback
    hold(16'h1D23, 3);
    check_val("wd_dir", 16'(p1_dir), 16'd4);
    hold(16'h23F0, 3);
    hold(16'hF023, 3);
    check_val("dbrk_dir", 16'(p1_dir), 16'd1);
    hold(16'h23F0, 3);
    hold(16'hF01D, 3);
    check_val("wbrk2_dir", 16'(p1_dir), 16'd0);

    // Unmatched code changes nothing
    hold(16'h0055, 3);
    check_val("unm_held", 16'(key_held), 16'h0000);

    // Space and game reset
    hold(16'h0029, 3);
`ifdef KEY_RESET_HOLD_EN
    check_val("gr_early", 16'(game_reset), 16'd0);
    hold(16'h0029, int'(HOLD));
    check_val("gr_hold", 16'(game_reset), 16'd1);
`else
    check_val("gr_now", 16'(game_reset), 16'd1);
`endif
    hold(16'h29F0, 3);
    hold(16'hF029, 3);
    check_val("gr_rel", 16'(game_reset), 16'd0);

    // Reset while the K make sits in LOOKUP
    hold(16'h0043, 3);
    check_val("i_dir", 16'(p2_dir), 16'd1);
    hold(16'h4342, 1);
    #2 rst = 1'b1;
    #1;
    check_zero("rstmid");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(16'h4342, 3);
    check_val("k_held", 16'(key_held), 16'h0040);
    check_val("k_dir", 16'(p2_dir), 16'd3);

    // Random byte stream, sometimes faster than the update path
    prev_b = 8'h42;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      k = int'($urandom_range(0, 9));
      if (r < 4) begin
        send(sc_tab[k]);
      end else if (r < 8) begin
        send(8'hF0);
        send(sc_tab[k]);
      end else begin
        send(8'($urandom_range(0, 255)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Central keyboard controller between the PS/2 receive path and game logic. It watches the two-byte keycode stream and decodes make and break codes for the ten game keys into a held-key bitmap plus one-cycle press pulses. It arbitrates each player's four direction keys into a single direction code and sequences the game-reset request. It replaces the per-key decoders with one scheduled update path.

## Interface
- `RESET_HOLD_CYCLES`, 65_000_000 — cycles the reset key must be held before `game_reset` asserts. Only used when `KEY_RESET_HOLD_EN` is defined.
- `clk` input 1 — system clock.
- `rst` input 1 — asynchronous, active-high reset.
- `keycode` input 16 — `[15:8]` is the previous byte and `[7:0]` is the latest byte from the PS/2 receiver. `8'hF0` in `[15:8]` marks a break code.
- `key_held` output 10 — held state per key index.
- `key_press` output 10 — one-cycle pulse on the 0→1 transition of `key_held`.
- `p1_dir` output 3 — player 1 direction code.
- `p2_dir` output 3 — player 2 direction code.
- `game_reset` output 1 — game reset request, level signal.

## Operation
- Key indices, with set-2 scancodes:
  - 0–3: W `1D`, A `1C`, S `1B`, D `23` (player 1 up/left/down/right).
  - 4–7: I `43`, J `3B`, K `42`, L `4B` (player 2 up/left/down/right).
  - 8: Space `29` (reset).
  - 9: Esc `76` (pause, passed through `key_held` only).
- Direction codes: 0 = none, 1 = up, 2 = left, 3 = down, 4 = right.
- An internal register `kc_q` holds the last processed keycode.
- FSM `IDLE → LOOKUP → APPLY → IDLE`:
  - IDLE: when `keycode != kc_q`, latch `keycode` into `kc_q` and go to LOOKUP. Otherwise stay.
  - LOOKUP: match `kc_q[7:0]` against the table to form a one-hot hit, and set break = (`kc_q[15:8] == F0`).
  - APPLY: on a make, set the hit bit; on a break, clear it. Pulse `key_press` only if the bit was previously 0. Update both arbiters. Return to IDLE.
- An unmatched code, or `F0` itself in `[7:0]`, passes through LOOKUP and APPLY with no state change.
- Typematic repeat leaves `keycode` unchanged, so it produces no event.
- Changes to `keycode` during LOOKUP or APPLY are not queued. The value present on return to IDLE is compared, so only the latest value is processed.
- Direction arbitration, per player:
  - A newly pressed direction key becomes the direction (last-pressed wins).
  - When the current direction key is released, fall back to the remaining held keys in priority up > left > down > right. If none is held, the direction is 0.
  - Releasing a non-current key leaves the direction unchanged.
- `game_reset` rules:
  - Without the macro, `game_reset` equals `key_held[8]`.
  - With the macro, see Configuration.

## Timing
- On `rst`, asynchronously:
  - `key_held`, `key_press`, `p1_dir`, `p2_dir` and `game_reset` = 0.
  - `kc_q` = 16'h0000, state = IDLE, hold counter = 0.
- Latency: `keycode` changes before edge N, so IDLE latches it at edge N. LOOKUP runs at N+1. All outputs update at edge N+2, visible in cycle N+2.
- `key_press` is high for exactly one cycle per press.
- Minimum spacing between processed events is 3 cycles.
- `rst` asserted mid-sequence aborts any pending LOOKUP or APPLY. A keycode present after release counts as new if it is non-zero.

## Configuration
- `KEY_RESET_HOLD_EN` defined:
  - A counter runs while `key_held[8]` = 1.
  - `game_reset` asserts on the cycle the count reaches `RESET_HOLD_CYCLES`, then saturates and stays high while the key is held.
  - Release clears both the counter and `game_reset` in the APPLY cycle.
  - Counter width is `$clog2(RESET_HOLD_CYCLES+1)`.
- `KEY_RESET_HOLD_EN` undefined: no counter exists, and `game_reset` = `key_held[8]` (immediate).

## Structure
- Package `key_pkg` contains:
  - Scancode localparams (`SC_W`… `SC_ESC`, `SC_BREAK = 8'hF0`).
  - Key index constants and `NUM_KEYS = 10`.
  - `dir_t` enum (`DIR_NONE`…`DIR_RIGHT`) and the FSM state enum.
- Sub-module `key_dir_arbiter` (clk, rst, 4-bit held, 4-bit press, out `dir_t`) is instantiated once per player.

## Test plan
- Reset, then drive `keycode` 16'h001D → after 2 cycles `key_held[0]` = 1, a one-cycle `key_press[0]`, `p1_dir` = 1.
- Drive `1D`, then `F0`, then `F01D` → `key_held[0]` = 0, `p1_dir` = 0, and no `key_press` on the break.
- P1 presses W (`1D`), then D (`1D23`) → `p1_dir` = 4. Break D (`F023`) → `p1_dir` = 1. Break W → `p1_dir` = 0.
- Hold `001D` constant for 100 cycles → exactly one `key_press[0]` pulse. Unmatched `0055` → all outputs unchanged.
- With `KEY_RESET_HOLD_EN` and `RESET_HOLD_CYCLES` = 20, press `0029` → `game_reset` rises after 20 cycles held. Break `F029` → falls in the APPLY cycle. Without the macro it rises 2 cycles after the keycode.
- Assert `rst` while in LOOKUP → all outputs 0 immediately, FSM in IDLE.
